// File: rtl/rom_access_controller_pkg.sv
// Shared types for the instruction ROM access controller:
// mode encoding, read tags and slot defaults.
package rom_access_controller_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    LOAD  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    TAG_NONE  = 2'd0,
    TAG_FETCH = 2'd1,
    TAG_DBG   = 2'd2
  } tag_e;

  localparam int unsigned FETCH_SLOT_DEFAULT  = 5;
  localparam int unsigned RESUME_SLOT_DEFAULT = 0;

  function automatic logic slot_hit(
    input logic [31:0] cnt,
    input int unsigned slot
  );
    return cnt == 32'(slot);
  endfunction

endpackage

// File: rtl/rom_read_tracker.sv
// Follows each ROM read from issue to data capture and routes
// MEM_RDATA to the fetch or debug destination.
module rom_read_tracker
  import rom_access_controller_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  tag_e              issue_tag_i,
  input  logic [DATA_W-1:0] rdata_i,
  output logic [DATA_W-1:0] instr_o,
  output logic [DATA_W-1:0] dbg_data_o,
  output logic              dbg_ack_o,
  output logic              busy_o,
  output logic              dbg_busy_o
);

  // tag_a rides with MEM_RE, tag_b with MEM_RDATA
  tag_e              tag_a_q;
  tag_e              tag_b_q;
  logic [DATA_W-1:0] instr_q;
  logic [DATA_W-1:0] dbg_data_q;
  logic              ack_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tag_a_q    <= TAG_NONE;
      tag_b_q    <= TAG_NONE;
      instr_q    <= '0;
      dbg_data_q <= '0;
      ack_q      <= 1'b0;
    end else begin
      tag_a_q <= issue_tag_i;
      tag_b_q <= tag_a_q;
      ack_q   <= (tag_b_q == TAG_DBG);
      if (tag_b_q == TAG_FETCH) instr_q <= rdata_i;
      if (tag_b_q == TAG_DBG) dbg_data_q <= rdata_i;
    end
  end

  assign instr_o    = instr_q;
  assign dbg_data_o = dbg_data_q;
  assign dbg_ack_o  = ack_q;
  assign busy_o     = (tag_a_q != TAG_NONE) ||
                      (tag_b_q != TAG_NONE);
  assign dbg_busy_o = (tag_a_q == TAG_DBG) ||
                      (tag_b_q == TAG_DBG);

endmodule

// File: rtl/rom_access_controller.sv
// Shares the single-port instruction ROM between CPU fetch,
// the boot loader and debug reads; owns the RUN/DRAIN/LOAD mode.
module rom_access_controller
  import rom_access_controller_pkg::*;
#(
  parameter int          ADDR_W      = 11,
  parameter int          DATA_W      = 16,
  parameter int unsigned FETCH_SLOT  = FETCH_SLOT_DEFAULT,
  parameter int unsigned RESUME_SLOT = RESUME_SLOT_DEFAULT
) (
  input  logic              CLK_100MHz,
  input  logic              RESET,
  input  logic              CLK_CPU,
  input  logic [31:0]       CLK_COUNT,
  input  logic [15:0]       PC,
  output logic [DATA_W-1:0] INSTRUCTION,
  output logic              CPU_HALT,
  input  logic              LOAD_EN,
  input  logic              LD_VALID,
  input  logic [ADDR_W-1:0] LD_ADDR,
  input  logic [DATA_W-1:0] LD_DATA,
  output logic              LD_READY,
  input  logic              DBG_REQ,
  input  logic [ADDR_W-1:0] DBG_ADDR,
  output logic              DBG_ACK,
  output logic [DATA_W-1:0] DBG_DATA,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic              MEM_RE,
  output logic              MEM_WE,
  output logic [DATA_W-1:0] MEM_WDATA,
  input  logic [DATA_W-1:0] MEM_RDATA
);

  state_e            state_q;
  logic              halt_q;
  logic              re_q;
  logic              we_q;
  logic              starve_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  logic fetch_go;
  logic ld_go;
  logic dbg_go;
  logic dbg_can;
  logic resume;
  logic busy;
  logic dbg_busy;
  tag_e issue_tag;
  logic unused_pc;

  assign unused_pc = ^PC[15:ADDR_W];

  assign resume   = slot_hit(CLK_COUNT, RESUME_SLOT);
  assign fetch_go = (state_q == RUN) && !halt_q &&
                    CLK_CPU &&
                    slot_hit(CLK_COUNT, FETCH_SLOT);
  assign dbg_can  = DBG_REQ && !dbg_busy;
  // a debug read that lost to the loader wins the next cycle
  assign ld_go    = LD_VALID && (state_q == LOAD) &&
                    !(dbg_can && starve_q);
  assign dbg_go   = dbg_can && !fetch_go && !ld_go;
  assign LD_READY = ld_go;

  always_comb begin
    issue_tag = TAG_NONE;
    unique case (1'b1)
      fetch_go: issue_tag = TAG_FETCH;
      dbg_go:   issue_tag = TAG_DBG;
      default:  issue_tag = TAG_NONE;
    endcase
  end

  always_ff @(posedge CLK_100MHz) begin
    if (RESET) begin
      state_q  <= RUN;
      halt_q   <= 1'b1;
      re_q     <= 1'b0;
      we_q     <= 1'b0;
      starve_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      re_q     <= fetch_go || dbg_go;
      we_q     <= ld_go;
      starve_q <= dbg_can && ld_go;
      if (fetch_go) begin
        addr_q <= PC[ADDR_W-1:0];
      end else if (ld_go) begin
        addr_q  <= LD_ADDR;
        wdata_q <= LD_DATA;
      end else if (dbg_go) begin
        addr_q <= DBG_ADDR;
      end
      unique case (state_q)
        RUN: begin
          if (LOAD_EN) begin
            state_q <= DRAIN;
            halt_q  <= 1'b1;
          end else if (resume) begin
            halt_q <= 1'b0;
          end
        end
        DRAIN: begin
          if (!busy) state_q <= LOAD;
        end
        LOAD: begin
          if (!LOAD_EN && !ld_go && resume) begin
            state_q <= RUN;
            halt_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= RUN;
          halt_q  <= 1'b1;
        end
      endcase
    end
  end

  rom_read_tracker #(
    .DATA_W(DATA_W)
  ) u_tracker (
    .clk_i      (CLK_100MHz),
    .rst_i      (RESET),
    .issue_tag_i(issue_tag),
    .rdata_i    (MEM_RDATA),
    .instr_o    (INSTRUCTION),
    .dbg_data_o (DBG_DATA),
    .dbg_ack_o  (DBG_ACK),
    .busy_o     (busy),
    .dbg_busy_o (dbg_busy)
  );

  assign CPU_HALT  = halt_q;
  assign MEM_RE    = re_q;
  assign MEM_WE    = we_q;
  assign MEM_ADDR  = addr_q;
  assign MEM_WDATA = wdata_q;

endmodule
